// File: rtl/cpu_defs.sv
// Shared CPU datapath definitions: multiplier FSM state encodings and width defaults.
package cpu_defs;

   localparam int MULT_WIDTH = 32;
   localparam int CNT_W      = $clog2(MULT_WIDTH + 2);

   typedef enum logic [1:0] {
      MULT_IDLE = 2'd0,
      MULT_RUN  = 2'd1,
      MULT_DONE = 2'd2
   } mult_state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the multiplicand into the
// accumulator, then an arithmetic right shift of {acc, q, q_1}.
module booth_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH+1:0] acc,
   input  logic [WIDTH:0]   q,
   input  logic             q_1,
   input  logic [WIDTH:0]   m,
   output logic [WIDTH+1:0] acc_next,
   output logic [WIDTH:0]   q_next,
   output logic             q_1_next
);

   logic [WIDTH+1:0] m_sxt;
   logic [WIDTH+1:0] sum;

   assign m_sxt = {m[WIDTH], m};

   always_comb begin
      // NOTE: sum gets a default first so no path through the case leaves it unassigned (no latch).
      sum = acc;
      unique case ({q[0], q_1})
         2'b01:   sum = acc + m_sxt;
         2'b10:   sum = acc - m_sxt;
         default: sum = acc;
      endcase
   end

   // Arithmetic shift: the accumulator MSB is replicated, the bit shifted out of q becomes q_1.
   assign acc_next = {sum[WIDTH+1], sum[WIDTH+1:1]};
   assign q_next   = {sum[0], q[WIDTH:1]};
   assign q_1_next = q[0];

endmodule

// File: rtl/mult.sv
// Sequential radix-2 Booth multiplier (MULT/MULTU): WIDTH+1 iterations over
// (WIDTH+1)-bit extended operands, product registered into hi/lo on completion.
module mult
   import cpu_defs::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_BITS = $clog2(WIDTH + 2);

   mult_state_t         state, state_next;
   logic [WIDTH+1:0]    acc, acc_step;
   logic [WIDTH:0]      m, q, q_step;
   logic                q_1, q_1_step;
   logic [CNT_BITS-1:0] cnt;
   logic                last_step;
   logic [2*WIDTH-1:0]  product;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc),
      .q        (q),
      .q_1      (q_1),
      .m        (m),
      .acc_next (acc_step),
      .q_next   (q_step),
      .q_1_next (q_1_step)
   );

   assign last_step = (cnt == CNT_BITS'(1));
   assign product   = {acc_step[WIDTH-2:0], q_step};

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) state <= MULT_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         MULT_IDLE: if (start) state_next = MULT_RUN;
         MULT_RUN:  if (last_step) state_next = MULT_DONE;
         MULT_DONE: state_next = MULT_IDLE;
         default:   state_next = MULT_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != MULT_IDLE);
      done = (state == MULT_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
         m   <= '0;
         q   <= '0;
         q_1 <= 1'b0;
         cnt <= '0;
         hi  <= '0;
         lo  <= '0;
      end else begin
         unique case (state)
            MULT_IDLE: begin
               if (start) begin
                  // Sign or zero extension by one bit is the only MULT/MULTU difference.
                  m   <= {is_signed & a[WIDTH-1], a};
                  q   <= {is_signed & b[WIDTH-1], b};
                  q_1 <= 1'b0;
                  acc <= '0;
                  cnt <= CNT_BITS'(WIDTH + 1);
               end
            end
            MULT_RUN: begin
               acc <= acc_step;
               q   <= q_step;
               q_1 <= q_1_step;
               cnt <= cnt - CNT_BITS'(1);
               if (last_step) begin
                  hi <= product[2*WIDTH-1:WIDTH];
                  lo <= product[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for mult: directed vector table, timing/abort sequences,
// and randomized back-to-back operations against a plain 64-bit multiply.
module tb_mult;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int errors = 0;
   int checks = 0;

   mult #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        s;
      logic [31:0] x;
      logic [31:0] y;
      logic [63:0] p;
   } vec_t;

   vec_t vecs[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy;
      logic [63:0] ux, uy;
      if (s) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         return 64'(sx * sy);
      end
      ux = {32'd0, x};
      uy = {32'd0, y};
      return ux * uy;
   endfunction

   // Issues one operation, waits for acceptance and for done, checks latency and product.
   task automatic run_op(input string name, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp);
      int  k;
      bit  ok;
      start = 1'b1; is_signed = s; a = x; b = y;
      ok = 1'b0;
      for (int i = 0; i < 4 && !ok; i++) begin
         tick();
         if (busy && !done) ok = 1'b1;
      end
      start = 1'b0;
      a = $urandom; b = $urandom; is_signed = 1'($urandom);
      if (!ok) begin
         check({name, " accept"}, 64'(busy), 64'(1));
         return;
      end
      k = 0;
      while (!done && k < 40) begin
         tick();
         k++;
      end
      check({name, " latency"}, 64'(k), 64'(33));
      check({name, " product"}, {hi, lo}, exp);
   endtask

   initial begin
      logic [63:0] prev;
      int          k;

      vecs.push_back('{"s 7*-3",        1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB});
      vecs.push_back('{"u max*max",     1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
      vecs.push_back('{"s -1*-1",       1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001});
      vecs.push_back('{"s min*min",     1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
      vecs.push_back('{"s min*1",       1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000});
      vecs.push_back('{"u min*min",     1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
      vecs.push_back('{"s max*max",     1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001});
      vecs.push_back('{"s min*max",     1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000});
      vecs.push_back('{"u 8000*2",      1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000});
      vecs.push_back('{"s 0*-1",        1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000});

      reset = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
      tick();
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset hilo", {hi, lo}, 64'd0);
      reset = 1'b1;
      tick();

      foreach (vecs[i]) run_op(vecs[i].name, vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].p);
      prev = vecs[vecs.size()-1].p;

      // Start held high continuously: one-cycle done, one idle cycle, then the next op.
      tick();
      start = 1'b1; is_signed = 1'b1; a = 32'd9; b = 32'hFFFF_FFFE;
      tick();
      check("hold busy at N", 64'(busy), 64'(1));
      k = 0;
      while (!done && k < 40) begin tick(); k++; end
      check("hold latency", 64'(k), 64'(33));
      check("hold product", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEE);
      tick();
      check("hold done pulse", 64'(done), 64'(0));
      check("hold idle gap", 64'(busy), 64'(0));
      tick();
      check("hold retake", 64'(busy), 64'(1));
      start = 1'b0;
      k = 0;
      while (!done && k < 40) begin tick(); k++; end
      check("hold 2nd latency", 64'(k), 64'(33));
      prev = 64'hFFFF_FFFF_FFFF_FFEE;
      tick();

      // Start pulsed mid-run with other operands must be ignored; hi/lo hold meanwhile.
      start = 1'b1; is_signed = 1'b1; a = 32'd7; b = 32'hFFFF_FFFD;
      tick();
      start = 1'b0;
      k = 0;
      while (!done && k < 40) begin
         tick();
         k++;
         if (k == 5) check("hilo hold", {hi, lo}, prev);
         if (k == 10) begin start = 1'b1; is_signed = 1'b0; a = 32'd1000; b = 32'd1000; end
         if (k == 11) start = 1'b0;
      end
      check("ignore latency", 64'(k), 64'(33));
      check("ignore product", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      tick();
      check("ignore no restart", 64'(busy), 64'(0));

      // Reset mid-run clears everything immediately with no done pulse.
      start = 1'b1; is_signed = 1'b0; a = 32'd12345; b = 32'd678;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b0;
      #1;
      check("abort busy", 64'(busy), 64'(0));
      check("abort done", 64'(done), 64'(0));
      check("abort hilo", {hi, lo}, 64'd0);
      tick();
      reset = 1'b1;
      tick();
      run_op("after reset 3*5", 1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F);

      // Random back-to-back ops: each new start is raised in the done cycle of the previous.
      for (int i = 0; i < 1500; i++) begin
         logic        s;
         logic [31:0] x, y;
         s = 1'($urandom);
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: x = 32'h8000_0000;
            1: y = 32'hFFFF_FFFF;
            default: ;
         endcase
         run_op("random", s, x, y, ref_mul(s, x, y));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
